// File: rtl/karatsuba_mult_pipe.sv
// karatsuba_mult_pipe: 5-stage pipelined 4-limb Karatsuba multiplier with valid/ready flow control.
// Define KARATSUBA_SQR_EN to add the in_sqr squaring-mode input.
module karatsuba_mult_pipe #(
  parameter int WIDTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
`ifdef KARATSUBA_SQR_EN
  input  logic               in_sqr,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);
  localparam int L = WIDTH / 4;
  // Cross-term pairs in order 10, 20, 30, 21, 31, 32
  localparam int PA [6] = '{1, 2, 3, 2, 3, 3};
  localparam int PB [6] = '{0, 0, 0, 1, 1, 2};

  if (LATENCY != 5) begin : g_bad_latency
    $error("karatsuba_mult_pipe: LATENCY must be 5");
  end
  if ((WIDTH % 4) != 0 || WIDTH < 16) begin : g_bad_width
    $error("karatsuba_mult_pipe: WIDTH must be a multiple of 4 and >= 16");
  end

  logic                adv;
  logic                sqr_c;
  logic                v1, v2, v3, v4;
  logic                s1_sqr;
  logic [L-1:0]        x_limb [4];
  logic [L-1:0]        y_limb [4];
  logic [L-1:0]        m_limb [4];
  logic [2*L-1:0]      s1_p   [4];
  logic [L:0]          s1_sx  [6];
  logic [L:0]          s1_sy  [6];
  logic [2*L+1:0]      s2_mp  [6];
  logic [2*L:0]        s2_ps  [6];
  logic [2*L-1:0]      s2_p   [4];
  logic [2*L+1:0]      m_diff [6];
  logic [5:0]          m_borrow;
  logic [2*L:0]        s3_m   [6];
  logic [2*L-1:0]      s3_p   [4];
  logic [2*L+1:0]      s4_t   [7];
  logic [2*WIDTH:0]    sum_c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !reset;

`ifdef KARATSUBA_SQR_EN
  assign sqr_c = in_sqr;
`else
  assign sqr_c = 1'b0;
`endif

  function automatic logic [2*WIDTH:0] ext_t(input logic [2*L+1:0] t);
    return {{(2*WIDTH-2*L-1){1'b0}}, t};
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_limb
    assign x_limb[i] = in_x[i*L +: L];
    assign y_limb[i] = in_y[i*L +: L];
    assign m_limb[i] = sqr_c ? x_limb[i] : y_limb[i];

    always_ff @(posedge clock) begin
      if (adv) begin
        s1_p[i] <= {{L{1'b0}}, x_limb[i]} * {{L{1'b0}}, m_limb[i]};
        s2_p[i] <= s1_p[i];
        s3_p[i] <= s2_p[i];
      end
    end
  end

  // Squaring mode reuses the X sums in stage 2 instead of the Y sums
  for (genvar k = 0; k < 6; k++) begin : g_pair
    assign m_diff[k]   = s2_mp[k] - {1'b0, s2_ps[k]};
    assign m_borrow[k] = m_diff[k][2*L+1];

    always_ff @(posedge clock) begin
      if (adv) begin
        s1_sx[k] <= {1'b0, x_limb[PA[k]]} + {1'b0, x_limb[PB[k]]};
        s1_sy[k] <= {1'b0, y_limb[PA[k]]} + {1'b0, y_limb[PB[k]]};
        s2_mp[k] <= {{(L+1){1'b0}}, s1_sx[k]} *
                    {{(L+1){1'b0}}, (s1_sqr ? s1_sx[k] : s1_sy[k])};
        s2_ps[k] <= {1'b0, s1_p[PA[k]]} + {1'b0, s1_p[PB[k]]};
        s3_m[k]  <= m_diff[k][2*L:0];
      end
    end
  end

  assign sum_c = ext_t(s4_t[0])
               + (ext_t(s4_t[1]) << L)
               + (ext_t(s4_t[2]) << (2*L))
               + (ext_t(s4_t[3]) << (3*L))
               + (ext_t(s4_t[4]) << (4*L))
               + (ext_t(s4_t[5]) << (5*L))
               + (ext_t(s4_t[6]) << (6*L));

  always_ff @(posedge clock) begin
    if (adv) begin
      s1_sqr  <= sqr_c;
      s4_t[0] <= {2'b00, s3_p[0]};
      s4_t[1] <= {1'b0, s3_m[0]};
      s4_t[2] <= {1'b0, s3_m[1]} + {2'b00, s3_p[1]};
      s4_t[3] <= {1'b0, s3_m[2]} + {1'b0, s3_m[3]};
      s4_t[4] <= {1'b0, s3_m[4]} + {2'b00, s3_p[2]};
      s4_t[5] <= {1'b0, s3_m[5]};
      s4_t[6] <= {2'b00, s3_p[3]};
    end
  end

  // Valid bits and the output register are the only state that needs reset
  always_ff @(posedge clock) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      out_valid <= v4;
      out_p     <= sum_c[2*WIDTH-1:0];
    end
  end

  // A borrow in the cross terms or a carry out of the final sum means broken arithmetic
  always_ff @(posedge clock) begin
    if (!reset && adv) begin
      if (v2) assert (m_borrow == 6'b0);
      if (v4) assert (!sum_c[2*WIDTH]);
    end
  end
endmodule

// File: tb/tb_karatsuba_mult_pipe.sv
// tb_karatsuba_mult_pipe: randomized scoreboard bench for karatsuba_mult_pipe at WIDTH=256.
// Squaring checks are included when KARATSUBA_SQR_EN is defined.
module tb_karatsuba_mult_pipe;
  localparam int W = 256;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
`ifdef KARATSUBA_SQR_EN
  logic           in_sqr;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;

  int             n_checks = 0;
  int             n_errors = 0;
  int             cycle = 0;
  int             run_len = 0;
  int             max_run = 0;
  int             last_out_cycle = -10;
  logic [2*W-1:0] sb [$];
  logic [2*W-1:0] cur_exp;
  logic [2*W-1:0] held_p;
  logic [2*W-1:0] s_out_p;
  logic           hold_pending;
  logic           accepted;
  logic           s_out_valid;
  logic           s_in_ready;

  karatsuba_mult_pipe #(.WIDTH(W), .LATENCY(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
`ifdef KARATSUBA_SQR_EN
    .in_sqr    (in_sqr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic sqr);
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    a = {{W{1'b0}}, x};
    b = {{W{1'b0}}, (sqr ? x : y)};
    return a * b;
  endfunction

  function automatic logic [W-1:0] randWide();
    logic [W-1:0] r;
    for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [2*W-1:0] observed,
                             input logic [2*W-1:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Samples one cycle at negedge+1, updates the scoreboard, then waits for the next negedge
  task automatic tick();
    logic [2*W-1:0] exp_p;
    #1;
    s_out_valid = out_valid;
    s_in_ready  = in_ready;
    s_out_p     = out_p;
    accepted    = 1'b0;
    if (reset) begin
      checkOutput("ready_in_reset", 512'(in_ready), 512'd0);
      sb.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", 512'(out_valid), 512'd1);
        checkOutput("hold_data", out_p, held_p);
      end
      hold_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", 512'(out_valid), 512'd0);
        end else begin
          exp_p = sb.pop_front();
          checkOutput("product", out_p, exp_p);
          run_len = (last_out_cycle == cycle - 1) ? run_len + 1 : 1;
          last_out_cycle = cycle;
          if (run_len > max_run) max_run = run_len;
        end
      end else if (out_valid) begin
        hold_pending = 1'b1;
        held_p = out_p;
      end
      accepted = in_valid && in_ready;
      if (accepted) sb.push_back(cur_exp);
    end
    cycle++;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [2*W-1:0] exp_p);
    in_valid = v;
    in_x     = x;
    in_y     = y;
    cur_exp  = exp_p;
    tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && guard < 60) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    checkOutput("drain_empty", 512'(sb.size()), 512'd0);
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         v;
    logic         seen;
    int           lat;

    reset        = 1'b1;
    in_valid     = 1'b0;
    in_x         = '0;
    in_y         = '0;
    out_ready    = 1'b1;
    cur_exp      = '0;
    held_p       = '0;
    hold_pending = 1'b0;
    accepted     = 1'b0;
`ifdef KARATSUBA_SQR_EN
    in_sqr       = 1'b0;
`endif
    @(negedge clock);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checkOutput("reset_out_valid", 512'(s_out_valid), 512'd0);
    checkOutput("reset_out_p", s_out_p, 512'd0);
    checkOutput("ready_after_reset", 512'(s_in_ready), 512'd1);

    // Single 1*1 transfer: valid exactly five cycles later for one cycle
    applyStimulus(1'b1, W'(1), W'(1), 512'd1);
    checkOutput("accept_1x1", 512'(accepted), 512'd1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      applyStimulus(1'b0, '0, '0, '0);
      if (s_out_valid) lat = i;
    end
    checkOutput("latency", 512'(lat), 512'd5);
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("single_pulse", 512'(s_out_valid), 512'd0);

    // Directed corner operands
    applyStimulus(1'b1, '1, '1, {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1});
    applyStimulus(1'b1, '0, randWide(), '0);
    applyStimulus(1'b1, randWide(), '0, '0);
    applyStimulus(1'b1, W'(64'h0123456789ABCDEF), W'(64'hFEDCBA9876543210),
                  512'(128'h0121FA00AD77D7422236D88FE5618CF0));
    drain();

    // Sixteen back-to-back pairs with the sink always ready
    max_run = 0;
    run_len = 0;
    for (int i = 0; i < 16; i++) begin
      x = randWide();
      y = randWide();
      applyStimulus(1'b1, x, y, model(x, y, 1'b0));
      checkOutput("b2b_ready", 512'(s_in_ready), 512'd1);
    end
    drain();
    checkOutput("b2b_run", 512'(max_run), 512'd16);

    // Three cycles of back-pressure while a product is presented
    x = randWide();
    y = randWide();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1'b1, x, y, model(x, y, 1'b0));
      if (accepted) begin
        x = randWide();
        y = randWide();
      end
      seen = s_out_valid;
    end
    checkOutput("stall_fill", 512'(seen), 512'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, x, y, model(x, y, 1'b0));
      checkOutput("stall_ready", 512'(s_in_ready), 512'd0);
      checkOutput("stall_valid", 512'(s_out_valid), 512'd1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, x, y, model(x, y, 1'b0));
      if (accepted) begin
        x = randWide();
        y = randWide();
      end
    end
    drain();

    // Reset with three operands in flight; none of them may ever appear
    for (int i = 0; i < 3; i++) begin
      x = randWide();
      y = randWide();
      applyStimulus(1'b1, x, y, model(x, y, 1'b0));
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    x = randWide();
    y = randWide();
    applyStimulus(1'b1, x, y, model(x, y, 1'b0));
    checkOutput("rst_mid_valid", 512'(s_out_valid), 512'd0);
    checkOutput("rst_mid_p", s_out_p, 512'd0);
    checkOutput("rst_mid_accept", 512'(accepted), 512'd1);
    drain();

`ifdef KARATSUBA_SQR_EN
    in_sqr = 1'b1;
    y = randWide();
    applyStimulus(1'b1, W'(16'hFFFF), y, 512'h0FFFE0001);
    x = randWide();
    applyStimulus(1'b1, x, y, model(x, y, 1'b1));
    in_sqr = 1'b0;
    drain();
`endif

    // Random traffic with random back-pressure; held requests keep their operands
    x = '0;
    y = '0;
    v = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!(in_valid && !accepted)) begin
        case ($urandom_range(0, 9))
          0:       x = '0;
          1:       x = '1;
          default: x = randWide();
        endcase
        y = ($urandom_range(0, 9) == 0) ? '1 : randWide();
        v = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(v, x, y, model(x, y, 1'b0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
